// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR random word generator.
package lfsr_pkg;

    // Tap mask for a maximal-length 32-bit XNOR LFSR (bits 31, 21, 1, 0).
    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

    typedef enum logic {
        GEN  = 1'b0,
        HOLD = 1'b1
    } gen_state_e;

    // Counter width able to hold 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prng_lfsr_gen_if.sv
// Control and output-stream signals of the LFSR random word generator.
interface prng_lfsr_gen_if #(
    parameter int WIDTH    = 32,
    parameter int OUT_BITS = 8
);
    logic                enable;
    logic                seed_valid;
    logic [WIDTH-1:0]    seed_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;
    logic [WIDTH-1:0]    state_out;
    logic                lockup;

    // The generator is the stream source.
    modport master (
        input  enable,
        input  seed_valid,
        input  seed_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output state_out,
        output lockup
    );

    modport slave (
        output enable,
        output seed_valid,
        output seed_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  state_out,
        input  lockup
    );
endinterface

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR state register with seed load and all-ones lock-up escape.
module lfsr_core #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] tapped;
    logic             feedback;
    logic             lock_hit;
    logic             lockup_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
        assign tapped[gi] = TAPS[gi] & state_reg[gi];
    end

    assign feedback = ~(^tapped);

    // All-ones is the XNOR lock-up state: never let it reach the register.
    always_comb begin
        candidate = state_reg;
        if (load) begin
            candidate = load_data;
        end else if (step) begin
            candidate = {state_reg[WIDTH-2:0], feedback};
        end
        lock_hit   = &candidate;
        state_next = lock_hit ? '0 : candidate;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= '0;
            lockup_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (lock_hit) begin
                lockup_reg <= 1'b1;
            end
        end
    end

    assign state  = state_reg;
    assign lockup = lockup_reg;

endmodule

// File: rtl/prng_lfsr_gen.sv
// Packs LFSR output bits into OUT_BITS-wide words and offers them over a valid/ready handshake.
module prng_lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
    parameter int               OUT_BITS = 8
) (
    input  logic           clock,
    input  logic           reset,
    prng_lfsr_gen_if.master bus
);

    localparam int               CNT_W    = cnt_width(OUT_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BITS - 1);

    gen_state_e          fsm_reg;
    gen_state_e          fsm_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [OUT_BITS-1:0] word_reg;
    logic [OUT_BITS-1:0] word_next;
    logic [OUT_BITS-1:0] word_shifted;
    logic                core_step;
    logic                core_load;
    logic [WIDTH-1:0]    core_state;
    logic                core_lockup;
    logic                capture_bit;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .step      (core_step),
        .load      (core_load),
        .load_data (bus.seed_data),
        .state     (core_state),
        .lockup    (core_lockup)
    );

    // The bit leaving the register on a step is the pre-step MSB.
    assign capture_bit = core_state[WIDTH-1];

    if (OUT_BITS == 1) begin : g_word_single
        assign word_shifted = capture_bit;
    end else begin : g_word_multi
        assign word_shifted = {word_reg[OUT_BITS-2:0], capture_bit};
    end

    always_comb begin
        fsm_next  = fsm_reg;
        cnt_next  = cnt_reg;
        word_next = word_reg;
        core_step = 1'b0;
        core_load = 1'b0;
        if (bus.seed_valid) begin
            // A seed restarts word assembly and drops whatever was pending.
            core_load = 1'b1;
            fsm_next  = GEN;
            cnt_next  = '0;
            word_next = '0;
        end else begin
            case (fsm_reg)
                GEN: begin
                    if (bus.enable) begin
                        core_step = 1'b1;
                        word_next = word_shifted;
                        cnt_next  = cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
                            fsm_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        fsm_next = GEN;
                        cnt_next = '0;
                    end
                end
                default: begin
                    fsm_next = GEN;
                    cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_reg  <= GEN;
            cnt_reg  <= '0;
            word_reg <= '0;
        end else begin
            fsm_reg  <= fsm_next;
            cnt_reg  <= cnt_next;
            word_reg <= word_next;
        end
    end

    assign bus.out_valid = (fsm_reg == HOLD);
    assign bus.out_data  = word_reg;
    assign bus.state_out = core_state;
    assign bus.lockup    = core_lockup;

endmodule

// File: doc/prng_lfsr_gen.md
PRNG_LFSR_GEN -- requirements
Module: prng_lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, LFSR state width (range 3..64).
REQ-002 SHALL have parameter TAPS, default 32'h8020_0003, WIDTH-bit tap mask; bit i set means state[i] feeds back.
REQ-003 SHALL have parameter OUT_BITS, default 8, bits per output word (range 1..WIDTH).
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, step permission; low freezes the LFSR state and bit count.
REQ-007 SHALL have port seed_valid, input, 1, one-cycle request to load seed_data.
REQ-008 SHALL have port seed_data, input, WIDTH, seed value.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a complete word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, OUT_BITS, packed random word, first-generated bit in the MSB.
REQ-012 SHALL have port state_out, output, WIDTH, current LFSR state.
REQ-013 SHALL have port lockup, output, 1, sticky flag: the all-ones lock-up state was detected.

Function
REQ-014 SHALL compute feedback = XNOR-reduction of state bits selected by TAPS.
REQ-015 SHALL advance one step as state <= {state[WIDTH-2:0], feedback}, at most one step per cycle.
REQ-016 SHALL capture pre-step state[WIDTH-1] into the word shift register on each step, MSB-first.
REQ-017 SHALL use FSM states GEN and HOLD.
REQ-018 In GEN, SHALL step on every cycle with enable high; after the OUT_BITS-th step, SHALL go to HOLD with out_valid=1 on the next cycle.
REQ-019 In HOLD, SHALL not step; out_data and out_valid SHALL stay stable until out_valid && out_ready.
REQ-020 On acceptance in HOLD, SHALL return to GEN with out_valid=0 and bit count 0 on the next cycle; no step occurs in the accept cycle (throughput: one word per OUT_BITS+1 cycles).
REQ-021 Enable low SHALL freeze state and bit count in GEN, and SHALL NOT affect a word already held in HOLD.
REQ-022 seed_valid SHALL have priority over stepping and acceptance: it loads state <= seed_data, clears the bit count and out_valid, and enters GEN, discarding any partial or held word.
REQ-023 If the loaded seed or the stepped state equals all-ones, SHALL set lockup=1 and force the state to all-zeros on the next cycle.
REQ-024 lockup SHALL clear only on reset.
REQ-025 With default parameters, SHALL give a maximal period of 2^32-1 outside the all-ones state.

Reset
REQ-026 On reset, SHALL set state=0, out_data=0, out_valid=0, lockup=0, bit count=0, FSM=GEN.
REQ-027 Reset SHALL override seed_valid, enable and out_ready in the same cycle.
REQ-028 Reset asserted mid-word or in HOLD SHALL discard the word without an accept.

Structure
REQ-029 SHALL place the default TAPS constant and the FSM state enum in a shared package lfsr_pkg.
REQ-030 SHALL place the state register, feedback and load/force-zero logic in one sub-module lfsr_core.
REQ-031 SHALL keep the FSM, bit counter, word packing and handshake in prng_lfsr_gen.

Verification
REQ-032 Defaults: reset, enable=1, out_ready=0 -> state sequence 0x1, 0x2, 0x4, 0x9, 0x12, 0x24, 0x49, 0x92; out_valid=1 with out_data=0x00 and state 0x00000092 held.
REQ-033 In HOLD, toggle enable and hold out_ready=0 for 20 cycles -> out_data and state_out unchanged; out_ready=1 for 1 cycle -> out_valid=0 next cycle, then stepping resumes.
REQ-034 seed_valid with seed_data=0x8000_0000 -> first 8 captured bits 1,0,0,0,0,0,0,0, so out_data=0x80.
REQ-035 seed_valid with seed_data=0xFFFF_FFFF -> lockup=1, state_out=0 the following cycle; lockup stays 1 until reset.
REQ-036 seed_valid during HOLD and after 3 steps of GEN -> word discarded, out_valid=0, new 8-step count starts from the seed.
REQ-037 WIDTH=4, TAPS=4'b1001, OUT_BITS=1, free-running from reset -> 15 distinct states before repeat; all-ones never reached.
